// File: rtl/eth_pkg.sv
// Shared LLC/transmitter encodings and the transmit-queue FSM state type.
// Pure declarations: no logic, no latency.
// No flow control of its own; consumers apply these encodings to req/ack and done_* fields.
package eth_pkg;

  typedef enum logic [1:0] {
    FAIL    = 2'd0,
    SUCCESS = 2'd1,
    NA      = 2'd2
  } transmission_status_t;

  typedef enum logic [0:0] {
    NOREQ = 1'b0,
    REQ   = 1'b1
  } req_type_t;

  typedef enum logic [1:0] {
    JAM = 2'd0,
    F   = 2'd1,
    ND  = 2'd2
  } send_type_t;

  localparam logic myFALSE = 1'b0;
  localparam logic myTRUE  = 1'b1;

  // Transmit-queue FSM state, kept as plain constants for legacy tools
  typedef logic [1:0] txq_state_t;
  localparam txq_state_t ST_IDLE = 2'd0;
  localparam txq_state_t ST_REQ  = 2'd1;
  localparam txq_state_t ST_GAP  = 2'd2;

endpackage

// File: rtl/txq_fifo.sv
// Tag FIFO holding queued frame requests; head is visible until popped.
// Write lands one edge after push; head/count/full/empty are register-derived.
// Caller qualifies push with !full and pop with !empty; full is a registered flag.
module txq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;

  // Occupancy after this edge; simultaneous push and pop cancel out
  always_comb begin
    count_nxt = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  end

  // Storage needs no reset: entries are only read once count covers them
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/llc_tx_queue.sv
// Transmit-request queue: serialises host frame requests onto the req/ack transmitter handshake.
// Push to req high takes 2 edges; req drops on the edge sampling a non-NA ack, done pulses next cycle.
// host_ready falls when full; done_* has no backpressure. Optional retry on Fail via TXQ_RETRY_EN.
module llc_tx_queue
  import eth_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 4,
  parameter int MAX_RETRY = 3,
  parameter int GAP_CYC   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         host_valid,
  input  logic [TAG_W-1:0]             host_tag,
  output logic                         host_ready,
  output logic                         req,
  input  logic [1:0]                   ack,
  output logic                         done_valid,
  output logic [TAG_W-1:0]             done_tag,
  output logic [1:0]                   done_status,
  output logic [2:0]                   done_tries,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int GW = $clog2(GAP_CYC+1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC-1);

  txq_state_t       state;
  logic [GW-1:0]    gap_cnt;
  logic [2:0]       tries;
  logic [TAG_W-1:0] head;
  logic             empty, full;
  logic             push, pop;
  logic             ack_ok, ack_fail, retry_take;

  assign host_ready = ~full;
  assign push       = host_valid & host_ready;
  // ack only matters while a request is outstanding; 3 falls through as NA
  assign ack_ok     = (state == ST_REQ) && (ack == SUCCESS);
  assign ack_fail   = (state == ST_REQ) && (ack == FAIL);
  // The head entry stays put across retries and leaves only with its completion
  assign pop        = ack_ok | (ack_fail & ~retry_take);

  txq_fifo #(.DEPTH(DEPTH), .W(TAG_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (host_tag),
    .head  (head),
    .count (q_count),
    .full  (full),
    .empty (empty)
  );

`ifdef TXQ_RETRY_EN
  localparam logic [2:0] MAX_RETRY_C = 3'(MAX_RETRY);
  logic retry_pend;

  assign retry_take = ack_fail && (tries <= MAX_RETRY_C);

  // Attempt counter: a fresh frame starts at 1, each retried Fail adds one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tries      <= 3'd0;
      retry_pend <= myFALSE;
    end else if (state == ST_IDLE && !empty) begin
      if (!retry_pend) tries <= 3'd1;
      retry_pend <= myFALSE;
    end else if (retry_take) begin
      tries      <= tries + 3'd1;
      retry_pend <= myTRUE;
    end
  end
`else
  localparam int unused_max_retry = MAX_RETRY;
  assign retry_take = 1'b0;
  assign tries      = 3'd1;
`endif

  // Request FSM: IDLE waits for work, REQ holds req until a status, GAP keeps req low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      req     <= NOREQ;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            state <= ST_REQ;
            req   <= REQ;
          end
        end
        ST_REQ: begin
          if (ack_ok || ack_fail) begin
            state   <= ST_GAP;
            req     <= NOREQ;
            gap_cnt <= '0;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          req   <= NOREQ;
        end
      endcase
    end
  end

  // Completion record: one-cycle valid, fields held until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_valid  <= 1'b0;
      done_tag    <= '0;
      done_status <= NA;
      done_tries  <= 3'd0;
    end else begin
      done_valid <= pop;
      if (pop) begin
        done_tag    <= head;
        done_status <= ack_ok ? SUCCESS : FAIL;
        done_tries  <= tries;
      end
    end
  end

endmodule

// File: tb/tb_llc_tx_queue.sv
module tb_llc_tx_queue;

  localparam int DEPTH     = 4;
  localparam int TAG_W     = 4;
  localparam int MAX_RETRY = 3;
  localparam int GAP_CYC   = 2;
`ifdef TXQ_RETRY_EN
  localparam int RETRY = 1;
`else
  localparam int RETRY = 0;
`endif

  localparam logic [1:0] A_FAIL = 2'd0;
  localparam logic [1:0] A_SUCC = 2'd1;
  localparam logic [1:0] A_NA   = 2'd2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             host_valid = 1'b0;
  logic [TAG_W-1:0] host_tag = '0;
  logic             host_ready;
  logic             req;
  logic [1:0]       ack = 2'd2;
  logic             done_valid;
  logic [TAG_W-1:0] done_tag;
  logic [1:0]       done_status;
  logic [2:0]       done_tries;
  logic [2:0]       q_count;

  llc_tx_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .MAX_RETRY(MAX_RETRY), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_tag(host_tag),
    .host_ready(host_ready), .req(req), .ack(ack), .done_valid(done_valid),
    .done_tag(done_tag), .done_status(done_status), .done_tries(done_tries),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: queued tags, attempts on the head frame, last completion record
  int mq[$];
  int attempt   = 0;
  int last_rise = -1;
  int cyc       = 0;
  int e_tag = 0, e_status = 2, e_tries = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    attempt = 0; last_rise = -1;
    e_tag = 0; e_status = 2; e_tries = 0;
  endtask

  // One clock: drive inputs, take the edge, update the model from what was offered, compare
  task automatic step(input logic hv, input logic [TAG_W-1:0] tg, input logic [1:0] a);
    logic hr_d, req_d;
    int exp_dv;
    host_valid = hv; host_tag = tg; ack = a;
    hr_d = host_ready; req_d = req;
    @(posedge clk); #1;
    cyc++;
    exp_dv = 0;
    if (req_d && (a == A_FAIL || a == A_SUCC)) begin
      chk("req_drop", req, 0);
      if (a == A_SUCC || RETRY == 0 || attempt > MAX_RETRY) begin
        exp_dv = 1;
        if (mq.size() > 0) e_tag = mq.pop_front();
        else chk("pop_nonempty", 0, 1);
        e_status = a;
        e_tries  = attempt;
        attempt  = 0;
      end
    end else if (req_d) begin
      chk("req_hold", req, 1);
    end
    if (hv && hr_d) mq.push_back(int'(tg));
    if (req && !req_d) begin
      attempt++;
      chk("req_nonempty", (mq.size() > 0) ? 1 : 0, 1);
      if (last_rise >= 0) chk("req_spacing", (cyc - last_rise >= GAP_CYC + 2) ? 1 : 0, 1);
      last_rise = cyc;
    end
    chk("done_valid", done_valid, exp_dv);
    chk("done_tag", done_tag, e_tag);
    chk("done_status", done_status, e_status);
    chk("done_tries", done_tries, e_tries);
    chk("q_count", q_count, mq.size());
    chk("host_ready", host_ready, (mq.size() != DEPTH) ? 1 : 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, A_NA);
  endtask

  // Wait (bounded) for req, then answer it; optional host push in the answer cycle
  task automatic complete_one(input logic [1:0] a, input logic hv, input logic [TAG_W-1:0] tg);
    bit got;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      if (req) begin
        step(hv, tg, a);
        got = 1;
      end else begin
        step(1'b0, '0, A_NA);
      end
    end
    if (!got) chk("req_timeout", 0, 1);
  endtask

  typedef struct {
    logic [TAG_W-1:0] tag;
    int               nfail;
    int               exp_status;
    int               exp_tries;
  } vec_t;

  vec_t tv[4];

  initial begin
    int given;
    bit seen;
    logic [1:0] a;

    tv[0] = '{4'd9,  0, 1, 1};
    tv[1] = '{4'd3,  1, (RETRY != 0) ? 1 : 0, (RETRY != 0) ? 2 : 1};
    tv[2] = '{4'd12, 9, 0, (RETRY != 0) ? MAX_RETRY + 1 : 1};
    tv[3] = '{4'd7,  3, (RETRY != 0) ? 1 : 0, (RETRY != 0) ? 4 : 1};

    // Reset values
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", req, 0);
    chk("rst_host_ready", host_ready, 1);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_tag", done_tag, 0);
    chk("rst_done_status", done_status, 2);
    chk("rst_done_tries", done_tries, 0);
    chk("rst_q_count", q_count, 0);
    #3 rst_n = 1'b1;
    model_reset();

    // Single frame: req two edges after push, Success completes it
    step(1'b1, 4'd5, A_NA);
    chk("t1_req_edge1", req, 0);
    step(1'b0, '0, A_NA);
    chk("t1_req_edge2", req, 1);
    step(1'b0, '0, A_SUCC);
    chk("t1_req_low", req, 0);
    chk("t1_done", done_valid, 1);
    chk("t1_tag", done_tag, 5);
    chk("t1_status", done_status, 1);
    chk("t1_tries", done_tries, 1);
    chk("t1_qcount", q_count, 0);
    idle(4);

    // Table of single frames with scripted Fail counts
    for (int i = 0; i < 4; i++) begin
      given = 0;
      seen  = 0;
      step(1'b1, tv[i].tag, A_NA);
      for (int c = 0; c < 200 && !seen; c++) begin
        if (req) begin
          a = (given < tv[i].nfail) ? A_FAIL : A_SUCC;
          step(1'b0, '0, a);
          given++;
        end else begin
          step(1'b0, '0, A_NA);
        end
        if (done_valid) begin
          seen = 1;
          chk("vec_tag", done_tag, tv[i].tag);
          chk("vec_status", done_status, tv[i].exp_status);
          chk("vec_tries", done_tries, tv[i].exp_tries);
          chk("vec_attempts", given, tv[i].exp_tries);
        end
      end
      if (!seen) chk("vec_timeout", 0, 1);
      idle(4);
    end

    // Fill to DEPTH, refused fifth offer, then pointer wrap with push-during-pop
    step(1'b1, 4'd1, A_NA);
    step(1'b1, 4'd2, A_NA);
    step(1'b1, 4'd3, A_NA);
    step(1'b1, 4'd4, A_NA);
    chk("full_qcount", q_count, 4);
    chk("full_ready", host_ready, 0);
    step(1'b1, 4'd9, A_NA);
    chk("full_refuse", q_count, 4);
    complete_one(A_SUCC, 1'b0, '0);
    chk("full_ready_back", host_ready, 1);
    chk("full_tag1", done_tag, 1);
    complete_one(A_SUCC, 1'b0, '0);
    chk("wrap_qcount_pre", q_count, 2);
    complete_one(A_SUCC, 1'b1, 4'd10);
    chk("wrap_qcount_same", q_count, 2);
    chk("wrap_tag3", done_tag, 3);
    complete_one(A_SUCC, 1'b0, '0);
    chk("wrap_tag4", done_tag, 4);
    complete_one(A_SUCC, 1'b0, '0);
    chk("wrap_tag10", done_tag, 10);
    idle(4);

    // Reset while req is high with three entries queued
    step(1'b1, 4'd1, A_NA);
    step(1'b1, 4'd2, A_NA);
    step(1'b1, 4'd3, A_NA);
    chk("mid_pre_req", req, 1);
    chk("mid_pre_count", q_count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_req", req, 0);
    chk("mid_count", q_count, 0);
    chk("mid_done", done_valid, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, A_SUCC);
      chk("stale_ack_done", done_valid, 0);
    end
    chk("stale_ack_req", req, 0);

    // Randomised traffic against the model
    for (int k = 0; k < 1500; k++) begin
      logic hv;
      logic [1:0] ra;
      int r;
      hv = ($urandom % 3) == 0;
      if (req) begin
        r = $urandom % 8;
        ra = (r < 3) ? A_NA : (r == 3) ? 2'd3 : (r < 6) ? A_FAIL : A_SUCC;
      end else begin
        ra = (($urandom % 4) == 0) ? 2'($urandom % 4) : A_NA;
      end
      step(hv, 4'($urandom % 16), ra);
    end

    // Drain everything left
    for (int k = 0; k < 400 && (mq.size() > 0 || req); k++)
      step(1'b0, '0, req ? A_SUCC : A_NA);
    chk("drain_model", mq.size(), 0);
    chk("drain_qcount", q_count, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
